// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encodings and the default operand width.
package add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fullAdder.sv
// Single-bit full-adder cell; the one arithmetic slice of the serial datapath.
module fullAdder (
   input  logic val1,
   input  logic val2,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = val1 ^ val2 ^ cin;
   assign cout = (val1 & val2) | (cin & (val1 ^ val2));

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract: one bit per cycle, LSB first, through a single
// full-adder cell, with a three-state IDLE/RUN/DONE controller.
module serial_add_sub_ctrl
   import add_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q, result_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q, cout_q, ovf_q;
   logic               fa_sum, fa_cout, last_bit;

   fullAdder u_fa (
      .val1 (a_q[0]),
      .val2 (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: b is inverted at capture and the carry seeds with op_sub.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= op_sub ? ~b : b;
                  carry_q <= op_sub;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_q      <= {1'b0, a_q[WIDTH-1:1]};
               b_q      <= {1'b0, b_q[WIDTH-1:1]};
               result_q <= {fa_sum, result_q[WIDTH-1:1]};
               carry_q  <= fa_cout;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  cout_q <= fa_cout;
                  ovf_q  <= carry_q ^ fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed bench for serial_add_sub_ctrl at WIDTH=8.
module tb_serial_add_sub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         op_sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, overflow;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   serial_add_sub_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Issue one operation and wait (bounded) for done; lat is cycles from the
   // accepting cycle to the done cycle, or -1 on timeout.
   task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic sub,
                        output int lat);
      int cyc;
      @(negedge clk);
      a = ai; b = bi; op_sub = sub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      lat = done ? cyc + 1 : -1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, result, cout, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%0b done=%0b result=%h cout=%0b ovf=%0b, required all 0",
                  busy, done, result, cout, overflow);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [W-1:0] va [3] = '{8'h05, 8'h7F, 8'hFF};
      logic [W-1:0] vb [3] = '{8'h03, 8'h01, 8'h01};
      logic [W-1:0] er [3] = '{8'h08, 8'h80, 8'h00};
      logic         ec [3] = '{1'b0, 1'b0, 1'b1};
      logic         ev [3] = '{1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], 1'b0, lat);
         checks++;
         if (lat !== W + 1) begin
            errors++;
            $display("FAIL add_latency[%0d]: got %0d cycles, required %0d", i, lat, W + 1);
         end
         checks++;
         if ({result, cout, overflow} !== {er[i], ec[i], ev[i]}) begin
            errors++;
            $display("FAIL add[%0d] %h+%h: result=%h cout=%0b ovf=%0b, required %h %0b %0b",
                     i, va[i], vb[i], result, cout, overflow, er[i], ec[i], ev[i]);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== er[i]) begin
            errors++;
            $display("FAIL add_hold[%0d]: done=%0b busy=%0b result=%h, required 0 0 %h",
                     i, done, busy, result, er[i]);
         end
      end
   endtask

   task automatic test_sub();
      logic [W-1:0] va [3] = '{8'h03, 8'h80, 8'h00};
      logic [W-1:0] vb [3] = '{8'h05, 8'h01, 8'h00};
      logic [W-1:0] er [3] = '{8'hFE, 8'h7F, 8'h00};
      logic         ec [3] = '{1'b0, 1'b1, 1'b1};
      logic         ev [3] = '{1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], 1'b1, lat);
         checks++;
         if (lat !== W + 1 || {result, cout, overflow} !== {er[i], ec[i], ev[i]}) begin
            errors++;
            $display("FAIL sub[%0d] %h-%h: lat=%0d result=%h cout=%0b ovf=%0b, required %0d %h %0b %0b",
                     i, va[i], vb[i], lat, result, cout, overflow, W + 1, er[i], ec[i], ev[i]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      logic [W-1:0] r = '0;
      @(negedge clk);
      a = 8'h05; b = 8'h03; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'hAA; b = 8'h55;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_busy: busy=%0b, required 1", busy);
      end
      a = 8'hFF; b = 8'hFF; op_sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (done) begin
            ndone++;
            r = result;
         end
         @(negedge clk);
      end
      checks++;
      if (ndone !== 1) begin
         errors++;
         $display("FAIL ignore_done_count: got %0d pulses, required 1", ndone);
      end
      checks++;
      if (r !== 8'h08) begin
         errors++;
         $display("FAIL ignore_result: got %h, required 08", r);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int ndone = 0;
      do_op(8'hFF, 8'h01, 1'b0, lat);
      @(negedge clk);
      a = 8'h6B; b = 8'h2D; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, result, cout, overflow} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: busy=%0b done=%0b result=%h cout=%0b ovf=%0b, required all 0",
                  busy, done, result, cout, overflow);
      end
      for (int i = 0; i < 15; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      checks++;
      if (ndone !== 0) begin
         errors++;
         $display("FAIL midrun_no_done: got %0d pulses, required 0", ndone);
      end
      do_op(8'h80, 8'h01, 1'b1, lat);
      checks++;
      if (lat !== W + 1 || {result, cout, overflow} !== {8'h7F, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL midrun_fresh: lat=%0d result=%h cout=%0b ovf=%0b, required %0d 7f 1 1",
                  lat, result, cout, overflow, W + 1);
      end
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      @(negedge clk);
      a = 8'h05; b = 8'h03; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done !== 1'b1 || result !== 8'h08) begin
         errors++;
         $display("FAIL b2b_first: done=%0b result=%h, required 1 08", done, result);
      end
      a = 8'h7F; b = 8'h01;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_gap: busy=%0b done=%0b, required 0 0", busy, done);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_accept: busy=%0b, required 1", busy);
      end
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== W || {result, cout, overflow} !== {8'h80, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_second: cyc=%0d result=%h cout=%0b ovf=%0b, required %0d 80 0 1",
                  cyc, result, cout, overflow, W);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_add_sub_ctrl.md
SERIAL_ADD_SUB_CTRL -- requirements
Module: serial_add_sub_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op_sub  input  1  0 = a+b, 1 = a-b; latched with operands.
REQ-006 a  input  WIDTH  first operand; latched on start acceptance.
REQ-007 b  input  WIDTH  second operand; latched on start acceptance.
REQ-008 busy  output  1  high while an operation is in progress (RUN).
REQ-009 done  output  1  one-cycle pulse: result, cout and overflow are valid.
REQ-010 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-011 cout  output  1  final carry-out; for subtract, 1 = no borrow.
REQ-012 overflow  output  1  signed (two's-complement) overflow of the operation.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE->RUN when start=1; a, b and op_sub SHALL be latched in that same cycle.
REQ-015 Subtraction SHALL be performed as a + ~b + 1: the latched b is inverted and the carry register is initialised to op_sub.
REQ-016 In RUN, one bit SHALL be processed per cycle, LSB first, through a single full-adder cell.
REQ-017 In RUN, the carry-out of each bit SHALL become the carry-in of the next bit.
REQ-018 A bit counter SHALL count 0..WIDTH-1; RUN->DONE after the cycle that processes bit WIDTH-1.
REQ-019 DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-020 Latency: done SHALL assert exactly WIDTH+1 cycles after the cycle in which start was accepted.
REQ-021 Sum bits SHALL shift into result from the MSB end; after the last bit, result holds the full word LSB-aligned.
REQ-022 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-023 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-024 start in RUN or DONE SHALL be ignored, with no queuing; a start held high through DONE is accepted on the following IDLE cycle.
REQ-025 result, cout and overflow SHALL hold their values from DONE until the next start is accepted.
REQ-026 Input changes on a and b after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-027 rst=1 SHALL force state IDLE; busy, done, result, cout, overflow, bit counter, carry and operand registers SHALL all be 0 on the next edge.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; reset has priority over start.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in shared package add_sub_pkg.
REQ-030 The bit-slice SHALL be one instance of the existing fullAdder sub-module (ports val1, val2, cin, sum, cout).
REQ-031 No other arithmetic operator SHALL be used on the datapath.

Verification
REQ-032 WIDTH=8, a=0x05, b=0x03, op_sub=0 -> result=0x08, cout=0, overflow=0, done exactly 9 cycles after start.
REQ-033 a=0x7F, b=0x01, add -> result=0x80, cout=0, overflow=1.
REQ-034 a=0xFF, b=0x01, add -> result=0x00, cout=1, overflow=0.
REQ-035 a=0x03, b=0x05, op_sub=1 -> result=0xFE, cout=0, overflow=0; and a=0x80, b=0x01, sub -> result=0x7F, overflow=1.
REQ-036 start pulsed again in RUN cycle 3 with new operands -> ignored; first result unchanged; exactly one done pulse.
REQ-037 rst asserted in RUN cycle 4 -> next cycle all outputs 0, busy=0, no done; a fresh start then completes correctly.
